// File: rtl/pc_pkg.sv
// ============================================================================
// pc_pkg : shared state encoding and default vectors for the PC fetch unit
// Rev 1.0
// ============================================================================
`default_nettype none

package pc_pkg;

   typedef enum logic [1:0] {
      ST_HOLD = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0100;
   localparam int unsigned DEF_INC          = 4;

endpackage

`default_nettype wire

// File: rtl/pc_next_sel.sv
// ============================================================================
// pc_next_sel : next-PC priority mux (trap > redirect > stall > accept)
// Rev 1.0
// ============================================================================
`default_nettype none

module pc_next_sel #(
   parameter int unsigned      XLEN        = 32,
   parameter logic [XLEN-1:0]  TRAP_VECTOR = 32'h0000_0100
) (
   input  logic            active_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic [XLEN-1:0] pc_plus_inc_i,
   input  logic            trap_i,
   input  logic            redirect_valid_i,
   input  logic [XLEN-1:0] redirect_target_i,
   input  logic            stall_i,
   input  logic            accept_i,
   output logic [XLEN-1:0] pc_d_o,
   output logic            misaligned_d_o
);

   always_comb begin
      pc_d_o         = pc_i;
      misaligned_d_o = 1'b0;
      if (active_i) begin
         if (trap_i) begin
            pc_d_o = TRAP_VECTOR;
         end else if (redirect_valid_i) begin
            // A misaligned target is converted into a trap rather than fetched.
            if (redirect_target_i[1:0] != 2'b00) begin
               pc_d_o         = TRAP_VECTOR;
               misaligned_d_o = 1'b1;
            end else begin
               pc_d_o = redirect_target_i;
            end
         end else if (!stall_i && accept_i) begin
            pc_d_o = pc_plus_inc_i;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/pc_fetch_unit.sv
// ============================================================================
// pc_fetch_unit : program counter with valid/ready fetch-request FSM
// Rev 1.0
// ============================================================================
`default_nettype none

module pc_fetch_unit
   import pc_pkg::*;
#(
   parameter int unsigned      XLEN         = 32,
   parameter logic [XLEN-1:0]  RESET_VECTOR = DEF_RESET_VECTOR,
   parameter logic [XLEN-1:0]  TRAP_VECTOR  = DEF_TRAP_VECTOR,
   parameter int unsigned      INC          = DEF_INC,
   parameter int unsigned      HOLD_CYCLES  = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_target,
   input  logic            trap_req,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_addr,
   output logic [XLEN-1:0] pc_out,
   output logic [XLEN-1:0] pc_plus_inc,
   output logic            misaligned
);

   localparam int unsigned     CNT_W     = $clog2(HOLD_CYCLES + 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [XLEN-1:0]  INC_V     = XLEN'(INC);

   state_t            state_q;
   logic [CNT_W-1:0]  hold_cnt_q;
   logic [XLEN-1:0]   pc_q;
   logic [XLEN-1:0]   pc_d;
   logic              misaligned_q;
   logic              misaligned_d;
   logic              active;
   logic              accept;

   assign active         = (state_q == ST_REQ) || (state_q == ST_WAIT);
   // WAIT never withdraws a request, even under stall.
   assign imem_req_valid = ((state_q == ST_REQ) && !stall) || (state_q == ST_WAIT);
   assign accept         = imem_req_valid && imem_req_ready;
   assign pc_plus_inc    = pc_q + INC_V;
   assign pc_out         = pc_q;
   assign imem_addr      = pc_q;
   assign misaligned     = misaligned_q;

   pc_next_sel #(
      .XLEN        (XLEN),
      .TRAP_VECTOR (TRAP_VECTOR)
   ) u_next_sel (
      .active_i          (active),
      .pc_i              (pc_q),
      .pc_plus_inc_i     (pc_plus_inc),
      .trap_i            (trap_req),
      .redirect_valid_i  (redirect_valid),
      .redirect_target_i (redirect_target),
      .stall_i           (stall),
      .accept_i          (accept),
      .pc_d_o            (pc_d),
      .misaligned_d_o    (misaligned_d)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_HOLD;
         hold_cnt_q   <= '0;
         pc_q         <= RESET_VECTOR;
         misaligned_q <= 1'b0;
      end else begin
         misaligned_q <= 1'b0;
         case (state_q)
            ST_HOLD: begin
               if (hold_cnt_q == HOLD_LAST) begin
                  state_q <= ST_REQ;
               end else begin
                  hold_cnt_q <= hold_cnt_q + CNT_W'(1);
               end
            end
            ST_REQ, ST_WAIT: begin
               pc_q         <= pc_d;
               misaligned_q <= misaligned_d;
               if (trap_req || redirect_valid) begin
                  state_q <= ST_REQ;
               end else if (stall) begin
                  state_q <= state_q;
               end else if (imem_req_ready) begin
                  state_q <= ST_REQ;
               end else begin
                  state_q <= ST_WAIT;
               end
            end
            default: state_q <= ST_HOLD;
         endcase
      end
   end

endmodule

`default_nettype wire
